// File: rtl/button_debounce.sv
// button_debounce: turns the raw active-low push-button pin into a clean
// debounced level plus single-cycle press, release and long-press events.
// The pin is synchronised into clk_i with two flops. A four-state FSM then
// filters bounces, and a hold counter times the long press.
module button_debounce #(
   parameter int DebounceCycles  = 500_000,
   parameter int LongPressCycles = 50_000_000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_ni,
   output logic pressed_o,
   output logic press_o,
   output logic release_o,
   output logic long_press_o
);

   localparam int DW = (DebounceCycles  > 1) ? $clog2(DebounceCycles)  : 1;
   localparam int HW = (LongPressCycles > 1) ? $clog2(LongPressCycles) : 1;

   localparam logic [DW-1:0] DEB_MAX  = DW'(DebounceCycles - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LongPressCycles - 1);

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   logic [1:0]    sync_q;
   logic          raw;

   state_t        state_q,     state_d;
   logic [DW-1:0] deb_q,       deb_d;
   logic [HW-1:0] hold_q,      hold_d;
   logic          long_done_q, long_done_d;
   logic          pressed_d, press_d, release_d, long_press_d;

   // Two-flop synchroniser for the asynchronous pin. Both flops reset to the
   // released level (1), so reset never looks like a press.
   // NOTE: sequential state uses non-blocking (<=) assignments so that every
   // flop samples the values from before the clock edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], btn_ni};
      end
   end

   // The pin is active-low, so raw is 1 while the button is pressed.
   assign raw = ~sync_q[1];

   // Next-state logic, counter updates and event decode. The outputs are
   // registered below, so every event appears on the edge of its transition.
   // NOTE: every signal gets a default value first. Without defaults, a
   // missed case branch would infer a latch.
   always_comb begin
      state_d      = state_q;
      deb_d        = deb_q;
      hold_d       = hold_q;
      long_done_d  = long_done_q;
      pressed_d    = pressed_o;
      press_d      = 1'b0;
      release_d    = 1'b0;
      long_press_d = 1'b0;

      case (state_q)
         RELEASED: begin
            if (raw) begin
               state_d = PRESS_WAIT;
               deb_d   = '0;
            end
         end

         PRESS_WAIT: begin
            if (!raw) begin
               // Bounce: the press was not stable long enough.
               state_d     = RELEASED;
               deb_d       = '0;
               long_done_d = 1'b0;
            end else if (deb_q == DEB_MAX) begin
               state_d   = HELD;
               deb_d     = '0;
               hold_d    = '0;
               press_d   = 1'b1;
               pressed_d = 1'b1;
            end else begin
               deb_d = deb_q + 1'b1;
            end
         end

         HELD: begin
            if (hold_q != HOLD_MAX) begin
               hold_d = hold_q + 1'b1;
            end
            if (hold_q == HOLD_MAX && !long_done_q) begin
               long_press_d = 1'b1;
               long_done_d  = 1'b1;
            end
            if (!raw) begin
               state_d = RELEASE_WAIT;
               deb_d   = '0;
            end
         end

         RELEASE_WAIT: begin
            // hold_cnt is frozen while a release is being qualified.
            if (raw) begin
               // Bounce: go back to HELD. hold_cnt and long_done keep their values.
               state_d = HELD;
               deb_d   = '0;
            end else if (deb_q == DEB_MAX) begin
               state_d     = RELEASED;
               deb_d       = '0;
               long_done_d = 1'b0;
               release_d   = 1'b1;
               pressed_d   = 1'b0;
            end else begin
               deb_d = deb_q + 1'b1;
            end
         end

         default: begin
            state_d = RELEASED;
            deb_d   = '0;
         end
      endcase
   end

   // FSM state, counters and registered outputs. An asynchronous reset
   // clears every output immediately and does not produce a release event.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= RELEASED;
         deb_q        <= '0;
         hold_q       <= '0;
         long_done_q  <= 1'b0;
         pressed_o    <= 1'b0;
         press_o      <= 1'b0;
         release_o    <= 1'b0;
         long_press_o <= 1'b0;
      end else begin
         state_q      <= state_d;
         deb_q        <= deb_d;
         hold_q       <= hold_d;
         long_done_q  <= long_done_d;
         pressed_o    <= pressed_d;
         press_o      <= press_d;
         release_o    <= release_d;
         long_press_o <= long_press_d;
      end
   end

endmodule
